// File: rtl/hist_peak_finder_pkg.sv
// Shared definitions for the histogram peak finder: FSM states, parameter defaults, histogram selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hist_peak_finder_pkg;

  localparam int NB_DEF        = 6;
  localparam int NOC_W_DEF     = 21;
  localparam int PIXEL_NUM_DEF = 16;
  localparam int MIN_COUNT_DEF = 1;

  // hist_sel encodings
  localparam logic HIST_CH = 1'b0;
  localparam logic HIST_FH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN_CH = 2'd1,
    ST_SCAN_FH = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/hist_peak_finder_tracker.sv
// Running argmax over a stream of bins; earliest arrival wins ties.
// Latency: maxNoc/maxAddr already include the bin presented this cycle (combinational look-ahead).
// Backpressure: none; every load_first/update cycle is consumed.
module peak_tracker
  import hist_peak_finder_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int NOC_W = NOC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_first,
  input  logic             update,
  input  logic [NB-1:0]    bin_addr,
  input  logic [NOC_W-1:0] bin_noc,
  output logic [NOC_W-1:0] maxNoc,
  output logic [NB-1:0]    maxAddr
);

  logic [NOC_W-1:0] runMax;
  logic [NB-1:0]    runAddr;

  // Best-so-far including the current bin: first bin loads, later bins replace only on a strictly larger count
  always_comb begin
    maxNoc  = runMax;
    maxAddr = runAddr;
    if (load_first) begin
      maxNoc  = bin_noc;
      maxAddr = bin_addr;
    end else if (update && (bin_noc > runMax)) begin
      maxNoc  = bin_noc;
      maxAddr = bin_addr;
    end
  end

  // Hold the running max between bins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      runMax  <= '0;
      runAddr <= '0;
    end else begin
      runMax  <= maxNoc;
      runAddr <= maxAddr;
    end
  end

endmodule

// File: rtl/hist_peak_finder.sv
// Per-pixel argmax over a coarse then a fine histogram; one result record per pixel.
// Latency: peak_valid pulses 1 cycle after the last fine bin is accepted; next pixel may start 2 cycles after it.
// Backpressure: none; out-of-order bins are dropped and flagged on sticky proto_err.
module hist_peak_finder
  import hist_peak_finder_pkg::*;
#(
  parameter int NB        = NB_DEF,
  parameter int NOC_W     = NOC_W_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bin_valid,
  input  logic [NB-1:0]                bin_addr,
  input  logic [NOC_W-1:0]             bin_noc,
  input  logic                         hist_sel,
  input  logic                         bin_last,
  output logic                         busy,
  output logic                         peak_valid,
  output logic [NB-1:0]                peak_ch,
  output logic [NB-1:0]                peak_fh,
  output logic [NOC_W-1:0]             peak_max,
  output logic                         peak_hit,
  output logic [$clog2(PIXEL_NUM)-1:0] pixel_idx,
  output logic                         proto_err
);

  localparam int IDX_W = $clog2(PIXEL_NUM);

  state_t           state;
  state_t           nextState;
  logic             isCh;
  logic             isFh;
  logic             trkLoad;
  logic             trkUpd;
  logic             chDone;
  logic             fhDone;
  logic             binErr;
  logic             fhFirst;
  logic [NB-1:0]    chPeak;
  logic [IDX_W-1:0] pixCnt;
  logic [NOC_W-1:0] trkMax;
  logic [NB-1:0]    trkAddr;

  assign isCh = bin_valid && (hist_sel == HIST_CH);
  assign isFh = bin_valid && (hist_sel == HIST_FH);

  // One tracker serves both passes since the coarse and fine scans never overlap
  peak_tracker #(
    .NB    (NB),
    .NOC_W (NOC_W)
  ) uTracker (
    .clk        (clk),
    .reset      (reset),
    .load_first (trkLoad),
    .update     (trkUpd),
    .bin_addr   (bin_addr),
    .bin_noc    (bin_noc),
    .maxNoc     (trkMax),
    .maxAddr    (trkAddr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: a single-bin coarse histogram goes straight from IDLE to the fine scan
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:    if (isCh) nextState = bin_last ? ST_SCAN_FH : ST_SCAN_CH;
      ST_SCAN_CH: if (isCh && bin_last) nextState = ST_SCAN_FH;
      ST_SCAN_FH: if (isFh && bin_last) nextState = ST_DONE;
      ST_DONE:    nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
  end

  // Output/control decode: tracker strobes, pass completion and protocol errors per state
  always_comb begin
    busy       = (state != ST_IDLE);
    peak_valid = (state == ST_DONE);
    trkLoad    = 1'b0;
    trkUpd     = 1'b0;
    chDone     = 1'b0;
    fhDone     = 1'b0;
    binErr     = 1'b0;
    case (state)
      ST_IDLE: begin
        trkLoad = isCh;
        chDone  = isCh && bin_last;
        binErr  = isFh;
      end
      ST_SCAN_CH: begin
        trkUpd = isCh;
        chDone = isCh && bin_last;
        binErr = isFh;
      end
      ST_SCAN_FH: begin
        trkLoad = isFh && fhFirst;
        trkUpd  = isFh && !fhFirst;
        fhDone  = isFh && bin_last;
        binErr  = isCh;
      end
      ST_DONE: begin
        binErr = bin_valid;
      end
      default: ;
    endcase
  end

  // Result registers: coarse peak is parked internally so published fields only change at the DONE boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fhFirst   <= 1'b0;
      chPeak    <= '0;
      pixCnt    <= '0;
      peak_ch   <= '0;
      peak_fh   <= '0;
      peak_max  <= '0;
      peak_hit  <= 1'b0;
      pixel_idx <= '0;
      proto_err <= 1'b0;
    end else begin
      if (binErr) proto_err <= 1'b1;
      if (chDone) begin
        chPeak  <= trkAddr;
        fhFirst <= 1'b1;
      end else if ((state == ST_SCAN_FH) && trkLoad) begin
        fhFirst <= 1'b0;
      end
      if (fhDone) begin
        peak_ch   <= chPeak;
        peak_fh   <= trkAddr;
        peak_max  <= trkMax;
        peak_hit  <= (trkMax >= NOC_W'(MIN_COUNT));
        pixel_idx <= pixCnt;
      end
      if (state == ST_DONE) begin
        pixCnt <= (pixCnt == IDX_W'(PIXEL_NUM - 1)) ? '0 : pixCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hist_peak_finder.sv
// Self-checking bench for hist_peak_finder: table vectors, random pixels vs. reference argmax, directed corners.
module tb_hist_peak_finder;

  logic        clk;
  logic        reset;
  logic        bin_valid;
  logic [5:0]  bin_addr;
  logic [20:0] bin_noc;
  logic        hist_sel;
  logic        bin_last;
  logic        busy;
  logic        peak_valid;
  logic [5:0]  peak_ch;
  logic [5:0]  peak_fh;
  logic [20:0] peak_max;
  logic        peak_hit;
  logic [3:0]  pixel_idx;
  logic        proto_err;

  hist_peak_finder dut (
    .clk        (clk),
    .reset      (reset),
    .bin_valid  (bin_valid),
    .bin_addr   (bin_addr),
    .bin_noc    (bin_noc),
    .hist_sel   (hist_sel),
    .bin_last   (bin_last),
    .busy       (busy),
    .peak_valid (peak_valid),
    .peak_ch    (peak_ch),
    .peak_fh    (peak_fh),
    .peak_max   (peak_max),
    .peak_hit   (peak_hit),
    .pixel_idx  (pixel_idx),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [20:0] noc;
  } bin_t;

  typedef struct {
    int base, n;
    int chA, chAv, chB, chBv;
    int fhA, fhAv, fhB, fhBv;
    int eCh, eFh, eMax, eHit;
  } vec_t;

  bin_t chQ[$];
  bin_t fhQ[$];
  int   total = 0;
  int   bad = 0;
  int   pvCount = 0;
  int   expIdx = 0;

  // count every result pulse so dropped or duplicated records show up
  always @(negedge clk) if (peak_valid) pvCount <= pvCount + 1;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBin(input bin_t b, input logic sel, input logic last);
    bin_valid = 1'b1;
    bin_addr  = b.addr;
    bin_noc   = b.noc;
    hist_sel  = sel;
    bin_last  = last;
    step();
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    hist_sel  = 1'b0;
  endtask

  // reference: find the maximum count, then the earliest bin holding it
  function automatic bin_t refPeak(input bit useFh);
    bin_t r;
    logic [20:0] m;
    int sz;
    m = '0;
    sz = useFh ? fhQ.size() : chQ.size();
    for (int i = 0; i < sz; i++) begin
      bin_t b;
      b = useFh ? fhQ[i] : chQ[i];
      if (b.noc > m) m = b.noc;
    end
    r = useFh ? fhQ[0] : chQ[0];
    for (int i = sz - 1; i >= 0; i--) begin
      bin_t b;
      b = useFh ? fhQ[i] : chQ[i];
      if (b.noc == m) r = b;
    end
    return r;
  endfunction

  task automatic sendPixel(input int injectAt, input int eCh, input int eFh, input int eMax,
                           input int eHit, input string tag);
    int pv0;
    pv0 = pvCount;
    foreach (chQ[i]) begin
      if (i == injectAt) begin
        bin_t junk;
        junk.addr = 6'd50;
        junk.noc  = 21'd1000;
        driveBin(junk, 1'b1, 1'b1);
      end
      driveBin(chQ[i], 1'b0, i == chQ.size() - 1);
    end
    foreach (fhQ[i]) driveBin(fhQ[i], 1'b1, i == fhQ.size() - 1);
    check({tag, ".valid"}, int'(peak_valid), 1);
    check({tag, ".ch"}, int'(peak_ch), eCh);
    check({tag, ".fh"}, int'(peak_fh), eFh);
    check({tag, ".max"}, int'(peak_max), eMax);
    check({tag, ".hit"}, int'(peak_hit), eHit);
    check({tag, ".idx"}, int'(pixel_idx), expIdx);
    step();
    check({tag, ".pulse"}, int'(peak_valid), 0);
    check({tag, ".count"}, pvCount - pv0, 1);
    expIdx = (expIdx + 1) % 16;
  endtask

  task automatic buildVec(input vec_t v);
    bin_t b;
    chQ.delete();
    fhQ.delete();
    for (int a = v.base; a < v.base + v.n; a++) begin
      b.addr = 6'(a);
      b.noc  = (a == v.chA) ? 21'(v.chAv) : (a == v.chB) ? 21'(v.chBv) : 21'd0;
      chQ.push_back(b);
      b.noc  = (a == v.fhA) ? 21'(v.fhAv) : (a == v.fhB) ? 21'(v.fhBv) : 21'd0;
      fhQ.push_back(b);
    end
  endtask

  task automatic buildRandom();
    int n, base;
    bin_t b;
    bit big;
    chQ.delete();
    fhQ.delete();
    n = $urandom_range(1, 64);
    base = $urandom_range(0, 64 - n);
    big = ($urandom_range(0, 3) == 0);
    for (int a = base; a < base + n; a++) begin
      b.addr = 6'(a);
      b.noc  = big ? 21'($urandom) : 21'($urandom_range(0, 15));
      chQ.push_back(b);
      b.noc  = big ? 21'($urandom) : 21'($urandom_range(0, 15));
      fhQ.push_back(b);
    end
  endtask

  task automatic sendRandom(input string tag);
    bin_t rc, rf;
    buildRandom();
    rc = refPeak(1'b0);
    rf = refPeak(1'b1);
    sendPixel(-1, int'(rc.addr), int'(rf.addr), int'(rf.noc), (rf.noc >= 21'd1) ? 1 : 0, tag);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{0, 64, 12, 50, 40, 20, 33, 80, 50, 79, 12, 33, 80, 1};
    tbl[1] = '{0, 16, 5, 7, 9, 7, 2, 3, 10, 3, 5, 2, 3, 1};
    tbl[2] = '{0, 64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{20, 8, 0, 0, 0, 0, 0, 0, 0, 0, 20, 20, 0, 0};
    tbl[4] = '{45, 1, 45, 4, 63, 9, 45, 6, 0, 9, 45, 45, 6, 1};
    tbl[5] = '{0, 64, 1, 100, 2, 101, 63, 2097151, 62, 2097150, 2, 63, 2097151, 1};
    tbl[6] = '{10, 20, 10, 1, 29, 1, 29, 1, 28, 0, 10, 29, 1, 1};

    reset = 1'b0;
    bin_valid = 1'b0;
    bin_addr = '0;
    bin_noc = '0;
    hist_sel = 1'b0;
    bin_last = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    check("rst.busy", int'(busy), 0);
    check("rst.valid", int'(peak_valid), 0);
    check("rst.ch", int'(peak_ch), 0);
    check("rst.max", int'(peak_max), 0);
    check("rst.idx", int'(pixel_idx), 0);
    check("rst.err", int'(proto_err), 0);

    // table-driven pixels, back to back
    for (int k = 0; k < 7; k++) begin
      buildVec(tbl[k]);
      sendPixel(-1, tbl[k].eCh, tbl[k].eFh, tbl[k].eMax, tbl[k].eHit, $sformatf("vec%0d", k));
    end

    // random pixels, back to back; index wraps past 15
    for (int k = 0; k < 20; k++) sendRandom($sformatf("rnd%0d", k));
    check("clean.err", int'(proto_err), 0);

    // coarse ramp then idle gap: busy must drop between pixels
    chQ.delete();
    fhQ.delete();
    for (int a = 0; a < 16; a++) begin
      bin_t b;
      b.addr = 6'(a);
      b.noc  = (a <= 12) ? 21'(a * 50 / 12) : 21'(10);
      chQ.push_back(b);
      b.noc  = (a == 9) ? 21'd80 : 21'd3;
      fhQ.push_back(b);
    end
    step();
    check("gap.busy", int'(busy), 0);
    sendPixel(-1, 12, 9, 80, 1, "ramp");

    // fine bin (flagged last) in the middle of a coarse scan: dropped, sticky error
    chQ.delete();
    fhQ.delete();
    begin
      int cv[6] = '{3, 9, 2, 4, 9, 1};
      int fv[3] = '{5, 7, 7};
      bin_t b;
      foreach (cv[i]) begin b.addr = 6'(i); b.noc = 21'(cv[i]); chQ.push_back(b); end
      foreach (fv[i]) begin b.addr = 6'(i); b.noc = 21'(fv[i]); fhQ.push_back(b); end
    end
    sendPixel(2, 1, 1, 7, 1, "proto");
    check("proto.err", int'(proto_err), 1);
    sendRandom("afterProto");
    check("proto.sticky", int'(proto_err), 1);

    // reset in the middle of the fine scan
    begin
      int pv0;
      bin_t b;
      b.addr = 6'd4; b.noc = 21'd9;
      driveBin(b, 1'b0, 1'b0);
      b.addr = 6'd5; b.noc = 21'd2;
      driveBin(b, 1'b0, 1'b1);
      b.addr = 6'd7; b.noc = 21'd30;
      driveBin(b, 1'b1, 1'b0);
      check("mid.busy", int'(busy), 1);
      pv0 = pvCount;
      reset = 1'b0;
      #2;
      check("mid.rst.busy", int'(busy), 0);
      check("mid.rst.valid", int'(peak_valid), 0);
      check("mid.rst.ch", int'(peak_ch), 0);
      check("mid.rst.fh", int'(peak_fh), 0);
      check("mid.rst.max", int'(peak_max), 0);
      check("mid.rst.hit", int'(peak_hit), 0);
      check("mid.rst.idx", int'(pixel_idx), 0);
      check("mid.rst.err", int'(proto_err), 0);
      step();
      step();
      reset = 1'b1;
      step();
      step();
      check("mid.noPulse", pvCount - pv0, 0);
      expIdx = 0;
    end
    buildVec(tbl[0]);
    sendPixel(-1, 12, 33, 80, 1, "postRst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
